// File: rtl/linear_sched_pkg.sv
// Shared types and helpers for the linear-layer tile scheduler.
package linear_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nested_tile_counter.sv
// Up to three nested wrap counters; index is the flattened position over the
// two inner levels, registered so it can drive an address port directly.
module nested_tile_counter
  import linear_sched_pkg::*;
#(
  parameter int LEVELS = 3,
  parameter int N0     = 1,
  parameter int N1     = 1,
  parameter int N2     = 1,
  parameter int IW     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] index,
  output logic          last
);

  localparam int E1  = (LEVELS > 1) ? N1 : 1;
  localparam int E2  = (LEVELS > 2) ? N2 : 1;
  localparam int C0W = safe_clog2(N0);
  localparam int C1W = safe_clog2(E1);
  localparam int C2W = safe_clog2(E2);

  logic [C0W-1:0] c0;
  logic [C1W-1:0] c1;
  logic [C2W-1:0] c2;
  logic           max0, max1, max2;

  // A level of size 1 is always at its maximum, so it is held at 0.
  assign max0 = (c0 == C0W'(N0 - 1));
  assign max1 = (c1 == C1W'(E1 - 1));
  assign max2 = (c2 == C2W'(E2 - 1));
  assign last = max0 && max1 && max2;

  // NOTE: state is updated with non-blocking assignments and cleared by the
  // asynchronous reset; the synchronous clear restarts the count for a new job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0    <= '0;
      c1    <= '0;
      c2    <= '0;
      index <= '0;
    end else if (clear) begin
      c0    <= '0;
      c1    <= '0;
      c2    <= '0;
      index <= '0;
    end else if (inc) begin
      index <= (max0 && max1) ? '0 : index + 1'b1;
      if (!max0) begin
        c0 <= c0 + 1'b1;
      end else begin
        c0 <= '0;
        if (!max1) begin
          c1 <= c1 + 1'b1;
        end else begin
          c1 <= '0;
          c2 <= max2 ? '0 : c2 + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fixed_linear_tile_scheduler.sv
// Issues weight/bias tile addresses in datapath consumption order and counts
// drained output tiles, pulsing done when the whole result has left.
module fixed_linear_tile_scheduler
  import linear_sched_pkg::*;
#(
  parameter int ITER_IN_Y    = 2,
  parameter int ITER_IN_X    = 3,
  parameter int ITER_W_Y     = 2,
  parameter int W_ADDR_WIDTH = safe_clog2(ITER_W_Y * ITER_IN_X),
  parameter int B_ADDR_WIDTH = safe_clog2(ITER_W_Y)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [W_ADDR_WIDTH-1:0] weight_addr,
  output logic                    weight_addr_valid,
  input  logic                    weight_addr_ready,
  output logic [B_ADDR_WIDTH-1:0] bias_addr,
  output logic                    bias_addr_valid,
  input  logic                    bias_addr_ready,
  input  logic                    out_beat
);

  localparam int BEATS  = ITER_IN_Y * ITER_W_Y;
  localparam int BEAT_W = safe_clog2(BEATS + 1);

  sched_state_t      state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              job_clear;
  logic              w_fire, b_fire;
  logic              w_last, b_last;
  logic              streams_empty;
  logic              beats_full;

  assign job_clear     = (state == IDLE) && start;
  assign w_fire        = weight_addr_valid && weight_addr_ready;
  assign b_fire        = bias_addr_valid && bias_addr_ready;
  assign streams_empty = !weight_addr_valid && !bias_addr_valid;
  assign beats_full    = (beat_cnt == BEAT_W'(BEATS));

  // Weights are re-streamed for every row tile: k inner, w middle, y outer.
  nested_tile_counter #(
    .LEVELS(3), .N0(ITER_IN_X), .N1(ITER_W_Y), .N2(ITER_IN_Y), .IW(W_ADDR_WIDTH)
  ) u_weight_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (job_clear),
    .inc   (w_fire),
    .index (weight_addr),
    .last  (w_last)
  );

  // Bias tiles are issued once; the datapath replays them per row tile.
  nested_tile_counter #(
    .LEVELS(1), .N0(ITER_W_Y), .N1(1), .N2(1), .IW(B_ADDR_WIDTH)
  ) u_bias_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (job_clear),
    .inc   (b_fire),
    .index (bias_addr),
    .last  (b_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      weight_addr_valid <= 1'b0;
      bias_addr_valid   <= 1'b0;
      beat_cnt          <= '0;
    end else begin
      if (w_fire && w_last) weight_addr_valid <= 1'b0;
      if (b_fire && b_last) bias_addr_valid   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state             <= RUN;
            busy              <= 1'b1;
            weight_addr_valid <= 1'b1;
            bias_addr_valid   <= 1'b1;
            beat_cnt          <= '0;
          end
        end
        RUN, DRAIN: begin
          if (out_beat && !beats_full) beat_cnt <= beat_cnt + 1'b1;
          // Completion is judged on registered stream and beat state.
          if (streams_empty && beats_full) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (streams_empty) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_linear_tile_scheduler.sv
// Bench for the tile scheduler: a job-level model checks every cycle, and
// directed scenarios pin sequences and latencies with literal values.
module tb_fixed_linear_tile_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic start_s [2];
  logic wrdy    [2];
  logic brdy    [2];
  logic beat    [2];
  logic busy_o  [2];
  logic done_o  [2];
  logic wv      [2];
  logic bv      [2];
  logic [2:0] wa0;
  logic [0:0] wa1;
  logic [0:0] ba0;
  logic [0:0] ba1;
  int   wa_i    [2];
  int   ba_i    [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    wa_i[0] = int'(wa0);
    wa_i[1] = int'(wa1);
    ba_i[0] = int'(ba0);
    ba_i[1] = int'(ba1);
  end

  fixed_linear_tile_scheduler u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .weight_addr(wa0), .weight_addr_valid(wv[0]), .weight_addr_ready(wrdy[0]),
    .bias_addr(ba0), .bias_addr_valid(bv[0]), .bias_addr_ready(brdy[0]),
    .out_beat(beat[0])
  );

  fixed_linear_tile_scheduler #(.ITER_IN_Y(3), .ITER_IN_X(1), .ITER_W_Y(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .weight_addr(wa1), .weight_addr_valid(wv[1]), .weight_addr_ready(wrdy[1]),
    .bias_addr(ba1), .bias_addr_valid(bv[1]), .bias_addr_ready(brdy[1]),
    .out_beat(beat[1])
  );

  function automatic int ix(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int iw(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int iy(input int d); return (d == 0) ? 2 : 3; endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- job-level model ----------------
  int wexp [2][16];
  int bexp [2][4];
  int wlen [2], whead [2], blen [2], bhead [2];
  bit in_job [2];
  int w_end [2], b_end [2], beat_end [2], done_cyc [2], beats [2];
  bit pwv [2], pwr [2], pbv [2], pbr [2];
  int pwa [2], pba [2];
  int obs_w [2][16];
  int obs_b [2][4];
  int n_obs_w [2], n_obs_b [2];
  int done_seen [2], n_done [2];

  task automatic model_reset(input int d);
    in_job[d] = 1'b0;
    wlen[d] = 0; whead[d] = 0; blen[d] = 0; bhead[d] = 0;
    pwv[d] = 1'b0; pwr[d] = 1'b0; pbv[d] = 1'b0; pbr[d] = 1'b0;
  endtask

  task automatic model_new_job(input int d);
    in_job[d] = 1'b1;
    wlen[d] = 0;
    for (int y = 0; y < iy(d); y++)
      for (int w = 0; w < iw(d); w++)
        for (int k = 0; k < ix(d); k++) begin
          wexp[d][wlen[d]] = w * ix(d) + k;
          wlen[d]++;
        end
    blen[d] = iw(d);
    for (int w = 0; w < iw(d); w++) bexp[d][w] = w;
    whead[d] = 0; bhead[d] = 0; beats[d] = 0;
    w_end[d] = -1; b_end[d] = -1; beat_end[d] = -1; done_cyc[d] = -1;
    n_obs_w[d] = 0; n_obs_b[d] = 0; n_done[d] = 0; done_seen[d] = -1;
  endtask

  task automatic model_step(input int d);
    bit was_idle;
    bit counting;
    int m;
    was_idle = !in_job[d];
    if (in_job[d] && done_cyc[d] < 0 && w_end[d] >= 0 && b_end[d] >= 0 && beat_end[d] >= 0) begin
      m = w_end[d];
      if (b_end[d] > m) m = b_end[d];
      if (beat_end[d] > m) m = beat_end[d];
      done_cyc[d] = m + 2;
    end

    check($sformatf("busy[%0d]", d), int'(busy_o[d]),
          int'(in_job[d] && (done_cyc[d] < 0 || cyc <= done_cyc[d])));
    check($sformatf("done[%0d]", d), int'(done_o[d]), int'(in_job[d] && cyc == done_cyc[d]));
    check($sformatf("wvalid[%0d]", d), int'(wv[d]), int'(in_job[d] && whead[d] < wlen[d]));
    check($sformatf("bvalid[%0d]", d), int'(bv[d]), int'(in_job[d] && bhead[d] < blen[d]));
    if (pwv[d] && !pwr[d]) check($sformatf("waddr_hold[%0d]", d), wa_i[d], pwa[d]);
    if (pbv[d] && !pbr[d]) check($sformatf("baddr_hold[%0d]", d), ba_i[d], pba[d]);

    if (wv[d] && wrdy[d] && whead[d] < wlen[d]) begin
      check($sformatf("waddr[%0d]", d), wa_i[d], wexp[d][whead[d]]);
      if (n_obs_w[d] < 16) begin obs_w[d][n_obs_w[d]] = wa_i[d]; n_obs_w[d]++; end
      whead[d]++;
      if (whead[d] == wlen[d]) w_end[d] = cyc;
    end
    if (bv[d] && brdy[d] && bhead[d] < blen[d]) begin
      check($sformatf("baddr[%0d]", d), ba_i[d], bexp[d][bhead[d]]);
      if (n_obs_b[d] < 4) begin obs_b[d][n_obs_b[d]] = ba_i[d]; n_obs_b[d]++; end
      bhead[d]++;
      if (bhead[d] == blen[d]) b_end[d] = cyc;
    end

    counting = in_job[d] && (done_cyc[d] < 0 || cyc < done_cyc[d]);
    if (counting && beat[d] && beats[d] < iy(d) * iw(d)) begin
      beats[d]++;
      if (beats[d] == iy(d) * iw(d)) beat_end[d] = cyc;
    end

    if (done_o[d]) begin
      n_done[d]++;
      done_seen[d] = cyc;
    end

    pwv[d] = wv[d]; pwr[d] = wrdy[d]; pwa[d] = wa_i[d];
    pbv[d] = bv[d]; pbr[d] = brdy[d]; pba[d] = ba_i[d];

    if (in_job[d] && cyc == done_cyc[d]) in_job[d] = 1'b0;
    if (was_idle && start_s[d]) model_new_job(d);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d, output int c);
    start_s[d] = 1'b1;
    c = cyc;
    tick();
    start_s[d] = 1'b0;
  endtask

  // Runs one job; beats are driven in cycles c+beat_from .. c+beat_from+beat_n-1.
  task automatic drive_job(input int d, input bit rand_rdy, input int beat_from,
                           input int beat_n, input int xs_a, input int xs_b,
                           input int probe_at, output int c);
    int i;
    pulse_start(d, c);
    i = 1;
    while (in_job[d] && i < 400) begin
      wrdy[d]    = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      brdy[d]    = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      beat[d]    = (i >= beat_from) && (i < beat_from + beat_n);
      start_s[d] = (i == xs_a) || (i == xs_b);
      if (i == probe_at) begin
        @(negedge clk);
        check("drain_busy", int'(busy_o[d]), 1);
        check("drain_wvalid", int'(wv[d]), 0);
        check("drain_bvalid", int'(bv[d]), 0);
      end
      tick();
      i++;
    end
    beat[d] = 1'b0; start_s[d] = 1'b0; wrdy[d] = 1'b1; brdy[d] = 1'b1;
    check("job_end_timeout", int'(in_job[d]), 0);
  endtask

  task automatic check_default_seq(input string tag);
    int exp_w [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    check({tag, "_nw"}, n_obs_w[0], 12);
    for (int i = 0; i < 12; i++) check({tag, "_wseq"}, obs_w[0][i], exp_w[i]);
    check({tag, "_nb"}, n_obs_b[0], 2);
    check({tag, "_b0"}, obs_b[0][0], 0);
    check({tag, "_b1"}, obs_b[0][1], 1);
    check({tag, "_ndone"}, n_done[0], 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"}, int'(busy_o[d]), 0);
      check({tag, "_done"}, int'(done_o[d]), 0);
      check({tag, "_wv"}, int'(wv[d]), 0);
      check({tag, "_bv"}, int'(bv[d]), 0);
      check({tag, "_wa"}, wa_i[d], 0);
      check({tag, "_ba"}, ba_i[d], 0);
    end
  endtask

  initial begin
    int c;
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; wrdy[d] = 1'b1; brdy[d] = 1'b1; beat[d] = 1'b0;
    end
    repeat (3) tick();
    check_zero_outputs("in_reset");
    rst = 1'b0;
    tick();
    check_zero_outputs("after_reset");

    // Ready high, four early beats: streams dominate, done at c+14.
    drive_job(0, 1'b0, 2, 4, -1, -1, -1, c);
    check_default_seq("basic");
    check("basic_latency", done_seen[0] - c, 14);
    tick();

    // 50% backpressure on both address streams.
    drive_job(0, 1'b1, 2, 4, -1, -1, -1, c);
    check_default_seq("bp");
    tick();

    // Five beats during RUN: the fifth is not counted, RUN goes straight to DONE.
    drive_job(0, 1'b0, 1, 5, -1, -1, -1, c);
    check_default_seq("early");
    check("early_latency", done_seen[0] - c, 14);
    tick();

    // Beats held off 20 cycles after the streams end: sits in DRAIN.
    drive_job(0, 1'b0, 33, 4, -1, -1, 25, c);
    check_default_seq("drain");
    check("drain_latency", done_seen[0] - c, 38);
    tick();

    // Asynchronous reset while weight_addr is 3, then a clean restart.
    pulse_start(0, c);
    n = 0;
    while (!(wv[0] && wa_i[0] == 3) && n < 20) begin
      tick();
      n++;
    end
    check("reached_addr3", int'(wv[0] && wa_i[0] == 3), 1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    drive_job(0, 1'b0, 2, 4, -1, -1, -1, c);
    check_default_seq("restart");
    check("restart_latency", done_seen[0] - c, 14);

    // Degenerate config: start during busy and in the DONE cycle is ignored.
    drive_job(1, 1'b0, 1, 3, 3, 5, -1, c);
    check("deg_nw", n_obs_w[1], 3);
    for (int i = 0; i < 3; i++) check("deg_wseq", obs_w[1][i], 0);
    check("deg_nb", n_obs_b[1], 1);
    check("deg_b0", obs_b[1][0], 0);
    check("deg_ndone", n_done[1], 1);
    check("deg_latency", done_seen[1] - c, 5);
    repeat (3) tick();
    check("deg_idle_busy", int'(busy_o[1]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
